sprite_blitter: RTL and testbench

- Streams one rectangular sprite from a selected image ROM into the vga_adapter pixel-write port (x, y, colour, plot).
- Sits between the animation sequencer, which issues start with position, size and image select, and vga_adapter.
- Generates linear ROM addresses and compensates for ROM read latency, so the emitted x/y/colour are always aligned.
- Clips to the 320x240 frame, optionally skips a transparent colour, and reports completion with a one-cycle done pulse.

---
 rtl/sprite_blitter_pkg.sv | 18 +
 rtl/sprite_blitter_pixel_delay_line.sv | 44 ++++
 rtl/sprite_blitter.sv | 240 ++++++++++++++++++++++++
 tb/tb_sprite_blitter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/sprite_blitter_pkg.sv
// Shared encodings for the sprite blitter: image selects, frame size, FSM states.
package sprite_blitter_pkg;

  localparam logic [1:0] SEL_CENTRE = 2'b01;
  localparam logic [1:0] SEL_RIGHT  = 2'b10;
  localparam logic [1:0] SEL_LEFT   = 2'b11;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/sprite_blitter_pixel_delay_line.sv
// Fixed-depth shift register carrying pixel coordinates alongside ROM reads,
// so the coordinates emerge in the same cycle as the ROM data they belong to.
module pixel_delay_line #(
  parameter int XW    = 10,
  parameter int YW    = 9,
  parameter int DEPTH = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [XW-1:0] in_x,
  input  logic [YW-1:0] in_y,
  input  logic          in_valid,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic          out_valid
);

  logic [DEPTH-1:0][XW-1:0] x_r;
  logic [DEPTH-1:0][YW-1:0] y_r;
  logic [DEPTH-1:0]         valid_r;

  // Shift every stage one step per cycle; clearing drops all in-flight entries.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_r     <= '0;
      y_r     <= '0;
      valid_r <= '0;
    end else begin
      x_r[0]     <= in_x;
      y_r[0]     <= in_y;
      valid_r[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        x_r[i]     <= x_r[i-1];
        y_r[i]     <= y_r[i-1];
        valid_r[i] <= valid_r[i-1];
      end
    end
  end

  assign out_x     = x_r[DEPTH-1];
  assign out_y     = y_r[DEPTH-1];
  assign out_valid = valid_r[DEPTH-1];

endmodule

// File: rtl/sprite_blitter.sv
// Streams one rectangular sprite from a selected image ROM into the VGA
// pixel-write port, clipping to the frame and optionally keying out a colour.
module sprite_blitter #(
  parameter int                  X_W                = 9,
  parameter int                  Y_W                = 8,
  parameter int                  ADDR_W             = 14,
  parameter int                  COLOUR_W           = 3,
  parameter int                  ROM_LATENCY        = 1,
  parameter int                  SCREEN_W           = sprite_blitter_pkg::SCREEN_W,
  parameter int                  SCREEN_H           = sprite_blitter_pkg::SCREEN_H,
  parameter bit                  TRANSPARENT_EN     = 1'b0,
  parameter logic [COLOUR_W-1:0] TRANSPARENT_COLOUR = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [X_W-1:0]      x0,
  input  logic [Y_W-1:0]      y0,
  input  logic [7:0]          width,
  input  logic [7:0]          height,
  input  logic [1:0]          sel,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [COLOUR_W-1:0] rom_colour_c,
  input  logic [COLOUR_W-1:0] rom_colour_r,
  input  logic [COLOUR_W-1:0] rom_colour_l,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot,
  output logic                busy,
  output logic                done
);

  import sprite_blitter_pkg::*;

  // One extra bit so coordinates past the top of the range clip instead of wrapping.
  localparam int XF_W = X_W + 1;
  localparam int YF_W = Y_W + 1;

  state_t              state_r;
  state_t              next_state_s;

  logic [X_W-1:0]      x0_r;
  logic [Y_W-1:0]      y0_r;
  logic [7:0]          width_r;
  logic [7:0]          height_r;
  logic [1:0]          sel_r;
  logic [7:0]          col_r;
  logic [7:0]          row_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [1:0]          drain_cnt_r;
  logic                busy_r;
  logic                done_r;

  logic                start_accept_s;
  logic                empty_s;
  logic                last_col_s;
  logic                last_row_s;
  logic                last_pixel_s;
  logic                drain_end_s;

  logic [XF_W-1:0]     issue_x_s;
  logic [YF_W-1:0]     issue_y_s;
  logic                issue_valid_s;
  logic [XF_W-1:0]     dl_x_s;
  logic [YF_W-1:0]     dl_y_s;
  logic                dl_valid_s;
  logic [COLOUR_W-1:0] rom_colour_s;
  logic                plot_s;

  // busy_r also covers the done cycle, which blocks a start arriving with the pulse.
  assign start_accept_s = start && !busy_r;
  assign empty_s        = (width == 8'd0) || (height == 8'd0);
  assign last_col_s     = (col_r == width_r - 8'd1);
  assign last_row_s     = (row_r == height_r - 8'd1);
  assign last_pixel_s   = last_col_s && last_row_s;
  assign drain_end_s    = (drain_cnt_r == 2'(ROM_LATENCY - 1));

  assign issue_x_s      = XF_W'(x0_r) + XF_W'(col_r);
  assign issue_y_s      = YF_W'(y0_r) + YF_W'(row_r);
  assign issue_valid_s  = (state_r == ISSUE);

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_accept_s) begin
          if (empty_s) begin
            next_state_s = DONE;
          end else begin
            next_state_s = ISSUE;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      ISSUE: begin
        if (last_pixel_s) begin
          next_state_s = DRAIN;
        end else begin
          next_state_s = ISSUE;
        end
      end
      DRAIN: begin
        if (drain_end_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = DRAIN;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Request latching, raster walk and drain counting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x0_r        <= '0;
      y0_r        <= '0;
      width_r     <= 8'd0;
      height_r    <= 8'd0;
      sel_r       <= 2'b00;
      col_r       <= 8'd0;
      row_r       <= 8'd0;
      addr_r      <= '0;
      drain_cnt_r <= 2'd0;
    end else begin
      case (state_r)
        IDLE: begin
          drain_cnt_r <= 2'd0;
          if (start_accept_s) begin
            x0_r     <= x0;
            y0_r     <= y0;
            width_r  <= width;
            height_r <= height;
            sel_r    <= sel;
            col_r    <= 8'd0;
            row_r    <= 8'd0;
            // An empty request never touches the ROM, so the address is left alone.
            if (!empty_s) begin
              addr_r <= '0;
            end
          end
        end
        ISSUE: begin
          // The final issue leaves rom_addr on the last address that was read.
          if (!last_pixel_s) begin
            addr_r <= addr_r + ADDR_W'(1);
            if (last_col_s) begin
              col_r <= 8'd0;
              row_r <= row_r + 8'd1;
            end else begin
              col_r <= col_r + 8'd1;
            end
          end
        end
        DRAIN: begin
          drain_cnt_r <= drain_cnt_r + 2'd1;
        end
        default: begin
          drain_cnt_r <= 2'd0;
        end
      endcase
    end
  end

  pixel_delay_line #(
    .XW    (XF_W),
    .YW    (YF_W),
    .DEPTH (ROM_LATENCY)
  ) u_delay (
    .clk       (clk),
    .reset     (reset),
    .in_x      (issue_x_s),
    .in_y      (issue_y_s),
    .in_valid  (issue_valid_s),
    .out_x     (dl_x_s),
    .out_y     (dl_y_s),
    .out_valid (dl_valid_s)
  );

  // Pick the image chosen at start and decide whether this pixel is written.
  always_comb begin
    rom_colour_s = rom_colour_c;
    case (sel_r)
      SEL_RIGHT:  rom_colour_s = rom_colour_r;
      SEL_LEFT:   rom_colour_s = rom_colour_l;
      SEL_CENTRE: rom_colour_s = rom_colour_c;
      default:    rom_colour_s = rom_colour_c;
    endcase
    plot_s = dl_valid_s
             && (dl_x_s < XF_W'(SCREEN_W))
             && (dl_y_s < YF_W'(SCREEN_H))
             && !(TRANSPARENT_EN && (rom_colour_s == TRANSPARENT_COLOUR));
  end

  // Registered pixel port; coordinates and colour hold while no entry is valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      vga_plot <= plot_s;
      if (dl_valid_s) begin
        vga_x      <= dl_x_s[X_W-1:0];
        vga_y      <= dl_y_s[Y_W-1:0];
        vga_colour <= rom_colour_s;
      end
    end
  end

  // Registered status: busy from the first issue cycle through the done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (next_state_s != IDLE) || (state_r == DONE);
      done_r <= (state_r == DONE);
    end
  end

  assign rom_addr = addr_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: three instances (default, transparent
// key enabled, three-cycle ROM) each fed by a small behavioural ROM.
module tb_sprite_blitter;

  logic       clk;
  logic       reset;
  logic [8:0] x0;
  logic [7:0] y0;
  logic [7:0] width;
  logic [7:0] height;
  logic [1:0] sel;

  logic        start_a, start_t, start_3;
  logic [13:0] rom_addr_a, rom_addr_t, rom_addr_3;
  logic [2:0]  rc_a, rr_a, rl_a, rc_t, rr_t, rl_t, rc_3, rr_3, rl_3;
  logic [8:0]  vx_a, vx_t, vx_3;
  logic [7:0]  vy_a, vy_t, vy_3;
  logic [2:0]  vc_a, vc_t, vc_3;
  logic        vp_a, vp_t, vp_3, busy_a, busy_t, busy_3, done_a, done_t, done_3;
  logic [13:0] p1_3, p2_3;

  int checks = 0;
  int errors = 0;
  int run_id = 0;

  sprite_blitter dut_a (
    .clk(clk), .reset(reset), .start(start_a), .x0(x0), .y0(y0),
    .width(width), .height(height), .sel(sel), .rom_addr(rom_addr_a),
    .rom_colour_c(rc_a), .rom_colour_r(rr_a), .rom_colour_l(rl_a),
    .vga_x(vx_a), .vga_y(vy_a), .vga_colour(vc_a), .vga_plot(vp_a),
    .busy(busy_a), .done(done_a)
  );

  sprite_blitter #(.TRANSPARENT_EN(1'b1), .TRANSPARENT_COLOUR(3'b000)) dut_t (
    .clk(clk), .reset(reset), .start(start_t), .x0(x0), .y0(y0),
    .width(width), .height(height), .sel(sel), .rom_addr(rom_addr_t),
    .rom_colour_c(rc_t), .rom_colour_r(rr_t), .rom_colour_l(rl_t),
    .vga_x(vx_t), .vga_y(vy_t), .vga_colour(vc_t), .vga_plot(vp_t),
    .busy(busy_t), .done(done_t)
  );

  sprite_blitter #(.ROM_LATENCY(3)) dut_3 (
    .clk(clk), .reset(reset), .start(start_3), .x0(x0), .y0(y0),
    .width(width), .height(height), .sel(sel), .rom_addr(rom_addr_3),
    .rom_colour_c(rc_3), .rom_colour_r(rr_3), .rom_colour_l(rl_3),
    .vga_x(vx_3), .vga_y(vy_3), .vga_colour(vc_3), .vga_plot(vp_3),
    .busy(busy_3), .done(done_3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROMs: centre = addr[2:0], right = ~addr[2:0], left = constant.
  assign rl_a = 3'd5;
  assign rl_t = 3'd6;
  assign rr_t = 3'd6;
  assign rl_3 = 3'd5;
  always @(posedge clk) begin
    rc_a <= rom_addr_a[2:0];
    rr_a <= ~rom_addr_a[2:0];
    rc_t <= rom_addr_t[0] ? rom_addr_t[2:0] : 3'd0;
    p1_3 <= rom_addr_3;
    p2_3 <= p1_3;
    rc_3 <= p2_3[2:0];
    rr_3 <= ~p2_3[2:0];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL run%0d %s: observed %0d expected %0d", run_id, tag, obs, exp);
    end
  endtask

  task automatic set_start(input int inst, input logic v);
    case (inst)
      0:       start_a = v;
      1:       start_t = v;
      default: start_3 = v;
    endcase
  endtask

  task automatic snap(input int inst, output logic [31:0] ra, output logic [31:0] vx,
                      output logic [31:0] vy, output logic [31:0] vc, output logic [31:0] vp,
                      output logic [31:0] bs, output logic [31:0] dn);
    case (inst)
      0: begin ra = 32'(rom_addr_a); vx = 32'(vx_a); vy = 32'(vy_a); vc = 32'(vc_a);
               vp = 32'(vp_a); bs = 32'(busy_a); dn = 32'(done_a); end
      1: begin ra = 32'(rom_addr_t); vx = 32'(vx_t); vy = 32'(vy_t); vc = 32'(vc_t);
               vp = 32'(vp_t); bs = 32'(busy_t); dn = 32'(done_t); end
      default: begin ra = 32'(rom_addr_3); vx = 32'(vx_3); vy = 32'(vy_3); vc = 32'(vc_3);
               vp = 32'(vp_3); bs = 32'(busy_3); dn = 32'(done_3); end
    endcase
  endtask

  // Start one blit and check every cycle against hand-derived timing:
  // pixel p is addressed in cycle p+1, plotted in cycle p+lat+2,
  // done in cycle n+lat+2 (cycle 2 for an empty sprite).
  task automatic run_blit(input int inst, input int bx, input int by, input int bw,
                          input int bh, input int bsel, input int lat, input bit tmode,
                          input int glitch);
    int n, done_c, p, ex, ey, ec, base;
    bit ep;
    logic [31:0] ra, vx, vy, vc, vp, bs, dn, prev_ra, exp_ra;
    run_id++;
    snap(inst, prev_ra, vx, vy, vc, vp, bs, dn);
    n = bw * bh;
    done_c = (n == 0) ? 2 : n + lat + 2;
    x0 = 9'(bx); y0 = 8'(by); width = 8'(bw); height = 8'(bh); sel = 2'(bsel);
    set_start(inst, 1'b1);
    @(negedge clk);
    set_start(inst, 1'b0);
    for (int c = 1; c <= done_c + 2; c++) begin
      if (c == glitch) begin
        x0 = 9'd200; y0 = 8'd50; width = 8'd1; height = 8'd1;
        set_start(inst, 1'b1);
      end
      snap(inst, ra, vx, vy, vc, vp, bs, dn);
      if (c <= n) exp_ra = 32'(c - 1);
      else if (n > 0) exp_ra = 32'(n - 1);
      else exp_ra = prev_ra;
      check($sformatf("c%0d rom_addr", c), ra, exp_ra);
      check($sformatf("c%0d busy", c), bs, 32'(c <= done_c));
      check($sformatf("c%0d done", c), dn, 32'(c == done_c));
      p = c - lat - 2;
      ep = 1'b0;
      ex = 0; ey = 0; ec = 0;
      if (n > 0 && p >= 0 && p < n) begin
        ex = bx + (p % bw);
        ey = by + (p / bw);
        base = p % 8;
        if (tmode && (base % 2 == 0)) base = 0;
        case (bsel)
          2: ec = tmode ? 6 : (7 - (p % 8));
          3: ec = tmode ? 6 : 5;
          default: ec = base;
        endcase
        ep = (ex < 320) && (ey < 240) && !(tmode && ec == 0);
      end
      check($sformatf("c%0d plot", c), vp, 32'(ep));
      if (ep) begin
        check($sformatf("c%0d x", c), vx, 32'(ex));
        check($sformatf("c%0d y", c), vy, 32'(ey));
        check($sformatf("c%0d colour", c), vc, 32'(ec));
      end
      @(negedge clk);
      set_start(inst, 1'b0);
    end
  endtask

  initial begin
    logic [31:0] ra, vx, vy, vc, vp, bs, dn;
    reset = 1'b0;
    start_a = 1'b0; start_t = 1'b0; start_3 = 1'b0;
    x0 = 9'd0; y0 = 8'd0; width = 8'd0; height = 8'd0; sel = 2'b00;
    repeat (3) @(negedge clk);

    // Reset state of all three instances.
    for (int i = 0; i < 3; i++) begin
      snap(i, ra, vx, vy, vc, vp, bs, dn);
      check($sformatf("reset%0d rom_addr", i), ra, 32'd0);
      check($sformatf("reset%0d vga_x", i), vx, 32'd0);
      check($sformatf("reset%0d vga_y", i), vy, 32'd0);
      check($sformatf("reset%0d colour", i), vc, 32'd0);
      check($sformatf("reset%0d plot", i), vp, 32'd0);
      check($sformatf("reset%0d busy", i), bs, 32'd0);
      check($sformatf("reset%0d done", i), dn, 32'd0);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);

    run_blit(0, 10, 20, 0, 5, 1, 1, 1'b0, -1);    // empty sprite
    run_blit(0, 10, 20, 4, 2, 1, 1, 1'b0, -1);    // basic 4x2 centre
    run_blit(0, 318, 20, 4, 1, 1, 1, 1'b0, -1);   // right-edge clip
    run_blit(0, 510, 255, 4, 2, 1, 1, 1'b0, -1);  // coordinate overflow never wraps
    run_blit(0, 10, 239, 2, 2, 3, 1, 1'b0, -1);   // bottom-edge clip, left image
    run_blit(0, 0, 0, 2, 1, 2, 1, 1'b0, 2);       // start mid-blit ignored, right image
    run_blit(0, 5, 5, 1, 1, 0, 1, 1'b0, 4);       // start during done pulse ignored
    run_blit(1, 10, 20, 4, 2, 1, 1, 1'b1, -1);    // transparent key
    run_blit(2, 10, 20, 4, 2, 2, 3, 1'b0, -1);    // three-cycle ROM, right image

    // Reset in the middle of a blit.
    run_id++;
    x0 = 9'd10; y0 = 8'd20; width = 8'd4; height = 8'd2; sel = 2'b01;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset plot before", 32'(vp_a), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("midreset plot", 32'(vp_a), 32'd0);
    check("midreset busy", 32'(busy_a), 32'd0);
    check("midreset rom_addr", 32'(rom_addr_a), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("midreset done %0d", c), 32'(done_a), 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 12; c++) begin
      check($sformatf("postreset idle done %0d", c), 32'(done_a), 32'd0);
      @(negedge clk);
    end
    run_blit(0, 10, 20, 4, 2, 1, 1, 1'b0, -1);    // behaves as from power-up

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
